// File: rtl/lab8_soc_sysinfo_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : lab8_soc_sysinfo_slave_if
//  Purpose  : Avalon-MM bus bundle for the system-info slave (no waitrequest).
//  Revision : 1.0  initial release
// ============================================================================
interface lab8_soc_sysinfo_slave_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/lab8_soc_sysinfo_slave.sv
`default_nettype none
// ============================================================================
//  Module   : lab8_soc_sysinfo_slave
//  Purpose  : System-info register block: ID, timestamp, 64-bit uptime with
//             coherent high-word shadow, capability word, scratch registers.
//  Revision : 1.0  initial release
// ============================================================================
module lab8_soc_sysinfo_slave #(
    parameter logic [31:0] ID_VALUE     = 32'h5AA8_76BF,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          NUM_SCRATCH  = 2,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
    input  logic                           clock,
    input  logic                           reset_n,
    lab8_soc_sysinfo_slave_if.slave        s_avmm
);

    localparam logic [31:0] c_cap = {16'h0, 4'h0, 4'(READ_LATENCY), 6'h0, 2'(NUM_SCRATCH)};

    logic [63:0]       r_uptime;
    logic [31:0]       r_shadow;
    logic [2:0][31:0]  w_scratch;
    logic [31:0]       w_rdata;
    logic              w_wr_acc;

    logic [READ_LATENCY-1:0] r_vld;
    logic [31:0]             r_dat [READ_LATENCY];

    // A simultaneous read wins; the write is dropped entirely.
    assign w_wr_acc = s_avmm.write && !s_avmm.read;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_uptime <= 64'd0;
            r_shadow <= 32'd0;
        end else begin
            r_uptime <= r_uptime + 64'd1;
            if (s_avmm.read && (s_avmm.address == 3'd2))
                r_shadow <= r_uptime[63:32];
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_scratch
        if (gi < NUM_SCRATCH) begin : g_impl
            localparam logic [2:0] c_addr = 3'(5 + gi);
            logic [31:0] r_word;

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_word <= SCRATCH_INIT;
                end else if (w_wr_acc && (s_avmm.address == c_addr)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_avmm.byteenable[b])
                            r_word[8*b +: 8] <= s_avmm.writedata[8*b +: 8];
                    end
                end
            end

            assign w_scratch[gi] = r_word;
        end else begin : g_none
            assign w_scratch[gi] = 32'd0;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (s_avmm.address)
            3'd0:    w_rdata = TIMESTAMP;
            3'd1:    w_rdata = ID_VALUE;
            3'd2:    w_rdata = r_uptime[31:0];
            3'd3:    w_rdata = r_shadow;
            3'd4:    w_rdata = c_cap;
            3'd5:    w_rdata = w_scratch[0];
            3'd6:    w_rdata = w_scratch[1];
            3'd7:    w_rdata = w_scratch[2];
            default: w_rdata = 32'd0;
        endcase
    end

    // Data is zeroed on entry when no read is accepted, so readdata is 0
    // whenever readdatavalid is low without any output gating.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_vld <= '0;
            for (int s = 0; s < READ_LATENCY; s++)
                r_dat[s] <= 32'd0;
        end else begin
            r_vld[0] <= s_avmm.read;
            r_dat[0] <= s_avmm.read ? w_rdata : 32'd0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_dat[s] <= r_dat[s-1];
            end
        end
    end

    assign s_avmm.readdata      = r_dat[READ_LATENCY-1];
    assign s_avmm.readdatavalid = r_vld[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_lab8_soc_sysinfo_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab8_soc_sysinfo_slave
//  Purpose  : Three differently parameterised slaves share one directed
//             stimulus stream and are checked against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lab8_soc_sysinfo_slave;

    localparam int          ND           = 3;
    localparam int          LAT  [ND]    = '{1, 3, 4};
    localparam int          NSC  [ND]    = '{2, 3, 0};
    localparam logic [31:0] IDV  [ND]    = '{32'h5AA8_76BF, 32'h5AA8_76BF, 32'hCAFE_0001};
    localparam logic [31:0] TSV  [ND]    = '{32'h0, 32'h1234_5678, 32'h0};
    localparam logic [31:0] INIT [ND]    = '{32'h0, 32'hA5A5_0F0F, 32'h0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  addr;
    logic        rd, wr;
    logic [31:0] wdata;
    logic [3:0]  be;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    lab8_soc_sysinfo_slave_if bus0();
    lab8_soc_sysinfo_slave_if bus1();
    lab8_soc_sysinfo_slave_if bus2();

    assign bus0.address = addr;  assign bus0.read = rd;  assign bus0.write = wr;
    assign bus0.writedata = wdata;  assign bus0.byteenable = be;
    assign bus1.address = addr;  assign bus1.read = rd;  assign bus1.write = wr;
    assign bus1.writedata = wdata;  assign bus1.byteenable = be;
    assign bus2.address = addr;  assign bus2.read = rd;  assign bus2.write = wr;
    assign bus2.writedata = wdata;  assign bus2.byteenable = be;

    lab8_soc_sysinfo_slave u_dut0 (
        .clock(clk), .reset_n(rst_n), .s_avmm(bus0)
    );
    lab8_soc_sysinfo_slave #(
        .ID_VALUE(32'h5AA8_76BF), .TIMESTAMP(32'h1234_5678), .NUM_SCRATCH(3),
        .READ_LATENCY(3), .SCRATCH_INIT(32'hA5A5_0F0F)
    ) u_dut1 (
        .clock(clk), .reset_n(rst_n), .s_avmm(bus1)
    );
    lab8_soc_sysinfo_slave #(
        .ID_VALUE(32'hCAFE_0001), .TIMESTAMP(32'h0), .NUM_SCRATCH(0),
        .READ_LATENCY(4), .SCRATCH_INIT(32'h0)
    ) u_dut2 (
        .clock(clk), .reset_n(rst_n), .s_avmm(bus2)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic [63:0] m_up [ND];
    logic [31:0] m_sh [ND];
    logic [31:0] m_sc [ND][3];
    exp_t        q    [ND][$];
    logic [31:0] rlog [ND][$];

    function automatic logic [31:0] model_read(int k, logic [2:0] a);
        case (a)
            3'd0: return TSV[k];
            3'd1: return IDV[k];
            3'd2: return m_up[k][31:0];
            3'd3: return m_sh[k];
            3'd4: return (32'(LAT[k]) << 8) | 32'(NSC[k]);
            default: return (int'(a) - 5 < NSC[k]) ? m_sc[k][int'(a) - 5] : 32'd0;
        endcase
    endfunction

    // Model: an accepted read becomes visible LAT-1 edges after the accept edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < ND; k++) begin
                if (!rst_n) begin
                    m_up[k] = 64'd0;
                    m_sh[k] = 32'd0;
                    for (int i = 0; i < 3; i++) m_sc[k][i] = INIT[k];
                    q[k].delete();
                end else begin
                    if (rd) begin
                        q[k].push_back('{due: cyc + LAT[k] - 1, data: model_read(k, addr)});
                        if (addr == 3'd2) m_sh[k] = m_up[k][63:32];
                    end else if (wr && addr >= 3'd5 && (int'(addr) - 5) < NSC[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) m_sc[k][int'(addr) - 5][8*b +: 8] = wdata[8*b +: 8];
                    end
                    m_up[k] = m_up[k] + 64'd1;
                end
            end
        end
    end

    function automatic logic get_vld(int k);
        case (k)
            0: return bus0.readdatavalid;
            1: return bus1.readdatavalid;
            default: return bus2.readdatavalid;
        endcase
    endfunction

    function automatic logic [31:0] get_dat(int k);
        case (k)
            0: return bus0.readdata;
            1: return bus1.readdata;
            default: return bus2.readdata;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                for (int k = 0; k < ND; k++) begin
                    logic        ev, av;
                    logic [31:0] ed, ad;
                    ev = (q[k].size() > 0) && (q[k][0].due == cyc);
                    ed = ev ? q[k][0].data : 32'd0;
                    av = get_vld(k);
                    ad = get_dat(k);
                    checks++;
                    if (av !== ev) begin
                        failures++;
                        $display("FAIL valid dut%0d cyc%0d: got %b expected %b", k, cyc, av, ev);
                    end
                    checks++;
                    if (ad !== ed) begin
                        failures++;
                        $display("FAIL rdata dut%0d cyc%0d: got %h expected %h", k, cyc, ad, ed);
                    end
                    if (ev) void'(q[k].pop_front());
                    if (av === 1'b1) rlog[k].push_back(ad);
                end
            end
        end
    end

    task automatic op(input logic r, input logic w, input logic [2:0] a,
                      input logic [31:0] d, input logic [3:0] b);
        rd = r; wr = w; addr = a; wdata = d; be = b;
        @(negedge clk);
    endtask

    task automatic lit(input int k, input int idx, input logic [31:0] exp);
        checks++;
        if (idx >= rlog[k].size()) begin
            failures++;
            $display("FAIL literal dut%0d idx%0d: got no result expected %h", k, idx, exp);
        end else if (rlog[k][idx] !== exp) begin
            failures++;
            $display("FAIL literal dut%0d idx%0d: got %h expected %h", k, idx, rlog[k][idx], exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 32'd0; be = 4'd0;
        @(negedge clk);
        op(1, 0, 3'd1, 32'd0, 4'h0);
        op(0, 1, 3'd5, 32'hFFFF_FFFF, 4'hF);
        op(0, 0, 3'd0, 32'd0, 4'h0);
        rst_n = 1'b1;
        op(1, 0, 3'd2, 32'd0, 4'h0);                // idx0: uptime 0
        op(1, 0, 3'd1, 32'd0, 4'h0);                // idx1,2: ID then TS
        op(1, 0, 3'd0, 32'd0, 4'h0);
        op(1, 0, 3'd0, 32'd0, 4'h0);                // idx3..6
        op(1, 0, 3'd1, 32'd0, 4'h0);
        op(1, 0, 3'd4, 32'd0, 4'h0);
        op(1, 0, 3'd1, 32'd0, 4'h0);
        op(0, 1, 3'd5, 32'hDEAD_BEEF, 4'b0101);
        op(1, 0, 3'd5, 32'd0, 4'h0);                // idx7
        op(0, 1, 3'd7, 32'hFFFF_FFFF, 4'hF);
        op(1, 0, 3'd7, 32'd0, 4'h0);                // idx8
        op(0, 1, 3'd1, 32'h1111_1111, 4'hF);
        op(0, 1, 3'd4, 32'h2222_2222, 4'hF);
        op(1, 0, 3'd1, 32'd0, 4'h0);                // idx9,10
        op(1, 0, 3'd4, 32'd0, 4'h0);
        op(1, 1, 3'd5, 32'h1111_1111, 4'hF);        // idx11
        op(1, 0, 3'd5, 32'd0, 4'h0);                // idx12
        op(1, 0, 3'd2, 32'd0, 4'h0);                // idx13,14
        op(1, 0, 3'd3, 32'd0, 4'h0);
        repeat (6) op(0, 0, 3'd0, 32'd0, 4'h0);
        op(1, 0, 3'd1, 32'd0, 4'h0);
        op(0, 0, 3'd0, 32'd0, 4'h0);
        rst_n = 1'b0;
        op(0, 0, 3'd0, 32'd0, 4'h0);
        rst_n = 1'b1;
        op(1, 0, 3'd2, 32'd0, 4'h0);
        op(1, 0, 3'd2, 32'd0, 4'h0);
        for (int i = 0; i < 40; i++)
            op(1'($urandom), 1'($urandom), 3'($urandom), $urandom, 4'($urandom));
        repeat (8) op(0, 0, 3'd0, 32'd0, 4'h0);

        for (int k = 0; k < ND; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                failures++;
                $display("FAIL drain dut%0d: got %0d pending expected 0", k, q[k].size());
            end
        end

        lit(0, 0, 32'h0);           lit(0, 1, 32'h5AA8_76BF);  lit(0, 2, 32'h0);
        lit(0, 5, 32'h0000_0102);   lit(0, 7, 32'h00AD_00EF);  lit(0, 8, 32'h0);
        lit(0, 11, 32'h00AD_00EF);  lit(0, 12, 32'h00AD_00EF); lit(0, 14, 32'h0);
        lit(0, 15, 32'h5AA8_76BF);  lit(0, 16, 32'h0);         lit(0, 17, 32'h1);
        lit(1, 2, 32'h1234_5678);   lit(1, 5, 32'h0000_0303);  lit(1, 7, 32'hA5AD_0FEF);
        lit(1, 8, 32'hFFFF_FFFF);   lit(1, 12, 32'hA5AD_0FEF); lit(1, 15, 32'h0);
        lit(1, 16, 32'h1);
        lit(2, 1, 32'hCAFE_0001);   lit(2, 5, 32'h0000_0400);  lit(2, 7, 32'h0);
        lit(2, 14, 32'h0);          lit(2, 15, 32'h0);         lit(2, 16, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
